// File: rtl/neighbor_exchange_receiver_if.sv
// Halo-exchange receive bus: per-neighbour write inputs and flow control in,
// merged activation-buffer write port and phase status out.
interface neighbor_exchange_receiver_if #(
  parameter int TILE_SIZE      = 128,
  parameter int NEIGHBOR_COUNT = 8
);
  localparam int CW = $clog2(TILE_SIZE);
  localparam int SW = $clog2(NEIGHBOR_COUNT);

  logic                               start;
  logic [NEIGHBOR_COUNT-1:0]          neighbor_present;
  logic [NEIGHBOR_COUNT-1:0][7:0]     neighbor_input_value;
  logic [NEIGHBOR_COUNT-1:0][CW-1:0]  neighbor_input_row;
  logic [NEIGHBOR_COUNT-1:0][CW-1:0]  neighbor_input_column;
  logic [NEIGHBOR_COUNT-1:0]          neighbor_input_write_enable;
  logic [NEIGHBOR_COUNT-1:0]          neighbor_exchange_done;
  logic [NEIGHBOR_COUNT-1:0]          neighbor_cts;
  logic [CW-1:0]                      buffer_row_write;
  logic [CW-1:0]                      buffer_column_write;
  logic [7:0]                         buffer_data_write;
  logic                               buffer_write_enable;
  logic [SW-1:0]                      buffer_write_source;
  logic                               receive_done;
  logic                               busy;
  logic                               overflow_error;

  modport master (
    output start, neighbor_present, neighbor_input_value, neighbor_input_row,
           neighbor_input_column, neighbor_input_write_enable, neighbor_exchange_done,
    input  neighbor_cts, buffer_row_write, buffer_column_write, buffer_data_write,
           buffer_write_enable, buffer_write_source, receive_done, busy, overflow_error
  );

  modport slave (
    input  start, neighbor_present, neighbor_input_value, neighbor_input_row,
           neighbor_input_column, neighbor_input_write_enable, neighbor_exchange_done,
    output neighbor_cts, buffer_row_write, buffer_column_write, buffer_data_write,
           buffer_write_enable, buffer_write_source, receive_done, busy, overflow_error
  );
endinterface

// File: rtl/neighbor_exchange_receiver.sv
// Buffers halo writes from up to NEIGHBOR_COUNT neighbour tiles in per-source FIFOs
// and merges them round-robin onto a single activation-buffer write port.
module neighbor_exchange_receiver #(
  parameter int TILE_SIZE      = 128,
  parameter int NEIGHBOR_COUNT = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  neighbor_exchange_receiver_if.slave   bus
);
  localparam int CW   = $clog2(TILE_SIZE);
  localparam int SW   = $clog2(NEIGHBOR_COUNT);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int EW   = 8 + 2 * CW;

  typedef enum logic [1:0] {IDLE, RECEIVE, DRAIN, DONE} state_t;

  state_t                            state_reg;
  logic [NEIGHBOR_COUNT-1:0]         done_mask_reg;
  logic [NEIGHBOR_COUNT-1:0]         cts_reg;
  logic [SW-1:0]                     last_grant_reg;
  logic [CW-1:0]                     row_reg;
  logic [CW-1:0]                     column_reg;
  logic [7:0]                        data_reg;
  logic                              write_enable_reg;
  logic [SW-1:0]                     source_reg;
  logic                              receive_done_reg;
  logic                              busy_reg;
  logic                              overflow_reg;

  logic                              active;
  logic [NEIGHBOR_COUNT-1:0]         fifo_empty;
  logic [NEIGHBOR_COUNT-1:0]         fifo_push;
  logic [NEIGHBOR_COUNT-1:0]         fifo_pop;
  logic [NEIGHBOR_COUNT-1:0]         fifo_drop;
  logic [NEIGHBOR_COUNT-1:0]         cts_next;
  logic [NEIGHBOR_COUNT-1:0][EW-1:0] fifo_head;
  logic                              grant_valid;
  logic [SW-1:0]                     grant_idx;
  logic [SW-1:0]                     cand;

  assign active = (state_reg == RECEIVE) || (state_reg == DRAIN);

  generate
    for (genvar gi = 0; gi < NEIGHBOR_COUNT; gi++) begin : g_src
      logic [EW-1:0]   mem [FIFO_DEPTH];
      logic [AW-1:0]   wr_ptr_reg;
      logic [AW-1:0]   rd_ptr_reg;
      logic [CNTW-1:0] count_reg;
      logic [CNTW-1:0] count_next;
      logic            full;

      assign full           = (count_reg == CNTW'(FIFO_DEPTH));
      assign fifo_empty[gi] = (count_reg == '0);
      assign fifo_pop[gi]   = grant_valid && (grant_idx == SW'(gi));
      // A pop on the same edge frees a slot, so a full FIFO still accepts.
      assign fifo_push[gi]  = bus.neighbor_input_write_enable[gi] && active &&
                              (!full || fifo_pop[gi]);
      assign fifo_drop[gi]  = bus.neighbor_input_write_enable[gi] && !fifo_push[gi];
      assign fifo_head[gi]  = mem[rd_ptr_reg];
      assign count_next     = count_reg + CNTW'(fifo_push[gi]) - CNTW'(fifo_pop[gi]);
      assign cts_next[gi]   = (CNTW'(FIFO_DEPTH) - count_next) >= CNTW'(2);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (fifo_push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (fifo_pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
          count_reg <= count_next;
        end
      end

      always_ff @(posedge clk) begin
        if (fifo_push[gi])
          mem[wr_ptr_reg] <= {bus.neighbor_input_value[gi], bus.neighbor_input_row[gi],
                              bus.neighbor_input_column[gi]};
      end
    end
  endgenerate

  // Round-robin: search upward from the source after the last grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NEIGHBOR_COUNT; k++) begin
      cand = SW'((int'(last_grant_reg) + k) % NEIGHBOR_COUNT);
      if (!grant_valid && !fifo_empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      done_mask_reg    <= '0;
      cts_reg          <= '0;
      last_grant_reg   <= SW'(NEIGHBOR_COUNT - 1);
      row_reg          <= '0;
      column_reg       <= '0;
      data_reg         <= '0;
      write_enable_reg <= 1'b0;
      source_reg       <= '0;
      receive_done_reg <= 1'b0;
      busy_reg         <= 1'b0;
      overflow_reg     <= 1'b0;
    end else begin
      write_enable_reg <= grant_valid;
      if (grant_valid) begin
        last_grant_reg <= grant_idx;
        source_reg     <= grant_idx;
        data_reg       <= fifo_head[grant_idx][EW-1 -: 8];
        row_reg        <= fifo_head[grant_idx][2*CW-1 -: CW];
        column_reg     <= fifo_head[grant_idx][CW-1:0];
      end

      if (state_reg == IDLE && bus.start) overflow_reg <= |fifo_drop;
      else                                overflow_reg <= overflow_reg | (|fifo_drop);

      case (state_reg)
        IDLE: begin
          receive_done_reg <= 1'b0;
          if (bus.start) begin
            state_reg     <= RECEIVE;
            done_mask_reg <= ~bus.neighbor_present;
            busy_reg      <= 1'b1;
            cts_reg       <= cts_next;
          end else begin
            busy_reg <= 1'b0;
            cts_reg  <= '0;
          end
        end
        RECEIVE: begin
          done_mask_reg <= done_mask_reg | bus.neighbor_exchange_done;
          busy_reg      <= 1'b1;
          cts_reg       <= cts_next;
          if (&done_mask_reg) state_reg <= DRAIN;
        end
        DRAIN: begin
          // A push landing on this edge keeps us draining.
          if ((&fifo_empty) && !(|fifo_push)) begin
            state_reg        <= DONE;
            busy_reg         <= 1'b0;
            cts_reg          <= '0;
            receive_done_reg <= 1'b1;
          end else begin
            busy_reg <= 1'b1;
            cts_reg  <= cts_next;
          end
        end
        default: begin
          state_reg        <= IDLE;
          receive_done_reg <= 1'b0;
          busy_reg         <= 1'b0;
          cts_reg          <= '0;
        end
      endcase
    end
  end

  assign bus.neighbor_cts        = cts_reg;
  assign bus.buffer_row_write    = row_reg;
  assign bus.buffer_column_write = column_reg;
  assign bus.buffer_data_write   = data_reg;
  assign bus.buffer_write_enable = write_enable_reg;
  assign bus.buffer_write_source = source_reg;
  assign bus.receive_done        = receive_done_reg;
  assign bus.busy                = busy_reg;
  assign bus.overflow_error      = overflow_reg;
endmodule

// File: tb/tb_neighbor_exchange_receiver.sv
// Directed bench for neighbor_exchange_receiver: stimulus pushes expected writes into
// per-source queues, a negedge monitor pops and compares every merged buffer write.
module tb_neighbor_exchange_receiver;
  localparam int NC = 8;

  typedef struct packed {
    logic [7:0] data;
    logic [6:0] row;
    logic [6:0] col;
  } entry_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   rd_cycles = 0;
  int   rd_base = 0;
  entry_t exp_q [NC][$];
  int     order_q[$];

  always #5 clk = ~clk;

  neighbor_exchange_receiver_if #(.TILE_SIZE(128), .NEIGHBOR_COUNT(NC)) bus ();

  neighbor_exchange_receiver #(.TILE_SIZE(128), .NEIGHBOR_COUNT(NC), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    int src;
    entry_t got;
    entry_t want;
    if (!reset) begin
      if (bus.receive_done) rd_cycles++;
      if (bus.buffer_write_enable) begin
        src      = int'(bus.buffer_write_source);
        got.data = bus.buffer_data_write;
        got.row  = bus.buffer_row_write;
        got.col  = bus.buffer_column_write;
        $display("write: source %0d row %0d col %0d data %02h", src, got.row, got.col, got.data);
        if (order_q.size() > 0) chk("write_source_order", src, order_q.pop_front());
        if (exp_q[src].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: source %0d data %02h, required no write", src, got.data);
        end else begin
          want = exp_q[src].pop_front();
          chk("write_entry", int'(got), int'(want));
        end
      end
    end
  end

  function automatic entry_t mk(input int s, input int n);
    entry_t e;
    e.data = 8'(s * 16 + n + 1);
    e.row  = 7'(s * 10 + n);
    e.col  = 7'(n * 3 + s);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.neighbor_input_write_enable = '0;
    bus.neighbor_exchange_done      = '0;
  endtask

  task automatic set_write(input int s, input entry_t e);
    bus.neighbor_input_value[s]        = e.data;
    bus.neighbor_input_row[s]          = e.row;
    bus.neighbor_input_column[s]       = e.col;
    bus.neighbor_input_write_enable[s] = 1'b1;
  endtask

  task automatic expect_write(input int s, input entry_t e, input bit ordered);
    exp_q[s].push_back(e);
    if (ordered) order_q.push_back(s);
  endtask

  task automatic do_reset();
    clear_inputs();
    bus.start = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic start_phase(input logic [NC-1:0] present);
    bus.neighbor_present = present;
    bus.start = 1'b1;
    rd_base = rd_cycles;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic all_done();
    bus.neighbor_exchange_done = '1;
    tick();
    clear_inputs();
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (rd_cycles == rd_base && n < budget) begin
      tick();
      n++;
    end
    repeat (4) tick();
    chk("receive_done_pulses", rd_cycles - rd_base, 1);
  endtask

  task automatic check_drained();
    int total = order_q.size();
    for (int s = 0; s < NC; s++) total += exp_q[s].size();
    chk("all_data_delivered", total, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    entry_t e;
    int     sent [NC];
    bit     saw_cts5_low;

    bus.start = 1'b0;
    bus.neighbor_present = '0;
    bus.neighbor_input_value = '0;
    bus.neighbor_input_row = '0;
    bus.neighbor_input_column = '0;
    clear_inputs();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_write_enable", int'(bus.buffer_write_enable), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_cts", int'(bus.neighbor_cts), 0);
    chk("reset_overflow", int'(bus.overflow_error), 0);
    chk("reset_data", int'(bus.buffer_data_write), 0);
    reset = 1'b0;

    // 1: single write from neighbour 3, two-edge latency
    do_reset();
    start_phase(8'hFF);
    chk("busy_after_start", int'(bus.busy), 1);
    chk("cts_after_start", int'(bus.neighbor_cts), 8'hFF);
    e.data = 8'h5A; e.row = 7'd7; e.col = 7'd9;
    expect_write(3, e, 1'b1);
    set_write(3, e);
    tick();
    clear_inputs();
    bus.neighbor_exchange_done = '1;
    tick();
    clear_inputs();
    chk("latency_write_enable", int'(bus.buffer_write_enable), 1);
    chk("latency_source", int'(bus.buffer_write_source), 3);
    chk("latency_data", int'(bus.buffer_data_write), 8'h5A);
    wait_done(20);
    chk("t1_overflow", int'(bus.overflow_error), 0);
    check_drained();

    // 2: all sources at once from reset priority -> order 0..7
    do_reset();
    start_phase(8'hFF);
    for (int s = 0; s < NC; s++) begin
      set_write(s, mk(s, 0));
      expect_write(s, mk(s, 0), 1'b1);
    end
    tick();
    clear_inputs();
    all_done();
    wait_done(30);
    chk("t2_overflow", int'(bus.overflow_error), 0);
    check_drained();

    // 3: sources 4,5,6 stream obeying cts
    do_reset();
    start_phase(8'hFF);
    for (int s = 0; s < NC; s++) sent[s] = 0;
    saw_cts5_low = 1'b0;
    for (int cyc = 0; cyc < 300 && (sent[4] + sent[5] + sent[6]) < 36; cyc++) begin
      clear_inputs();
      if (!bus.neighbor_cts[5]) saw_cts5_low = 1'b1;
      for (int s = 4; s <= 6; s++) begin
        if (bus.neighbor_cts[s] && sent[s] < 12) begin
          set_write(s, mk(s, sent[s]));
          expect_write(s, mk(s, sent[s]), 1'b0);
          sent[s]++;
        end
      end
      tick();
    end
    clear_inputs();
    chk("t3_all_sent", sent[4] + sent[5] + sent[6], 36);
    chk("t3_cts5_deasserted", int'(saw_cts5_low), 1);
    all_done();
    wait_done(60);
    chk("t3_overflow", int'(bus.overflow_error), 0);
    check_drained();

    // 4: source 2 ignores cts; its 6th write is dropped
    do_reset();
    start_phase(8'hFF);
    for (int n = 0; n < 6; n++) begin
      clear_inputs();
      for (int s = 0; s <= 2; s++) begin
        set_write(s, mk(s, n));
        if (!(s == 2 && n == 5)) expect_write(s, mk(s, n), 1'b0);
      end
      tick();
    end
    clear_inputs();
    chk("t4_overflow_set", int'(bus.overflow_error), 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t4_start_ignored_in_receive", int'(bus.overflow_error), 1);
    all_done();
    wait_done(40);
    chk("t4_overflow_sticky", int'(bus.overflow_error), 1);
    check_drained();
    start_phase(8'hFF);
    chk("t4_overflow_cleared_by_start", int'(bus.overflow_error), 0);

    // 5: only neighbour 0 present; IDLE write sets overflow
    do_reset();
    start_phase(8'h01);
    for (int n = 0; n < 2; n++) begin
      set_write(0, mk(0, n));
      expect_write(0, mk(0, n), 1'b1);
      tick();
    end
    clear_inputs();
    bus.neighbor_exchange_done[0] = 1'b1;
    tick();
    clear_inputs();
    wait_done(20);
    chk("t5_overflow_before_idle_write", int'(bus.overflow_error), 0);
    check_drained();
    set_write(3, mk(3, 0));
    tick();
    clear_inputs();
    repeat (3) tick();
    chk("t5_idle_write_overflow", int'(bus.overflow_error), 1);
    chk("t5_idle_busy", int'(bus.busy), 0);

    // 6: reset in DRAIN with 3 entries buffered
    do_reset();
    start_phase(8'hFF);
    all_done();
    tick();
    for (int s = 0; s < 4; s++) set_write(s, mk(s, 1));
    expect_write(0, mk(0, 1), 1'b1);
    tick();
    clear_inputs();
    @(posedge clk);
    #7;
    chk("t6_busy_in_drain", int'(bus.busy), 1);
    reset = 1'b1;
    #1;
    chk("t6_reset_write_enable", int'(bus.buffer_write_enable), 0);
    chk("t6_reset_busy", int'(bus.busy), 0);
    chk("t6_reset_cts", int'(bus.neighbor_cts), 0);
    chk("t6_reset_source", int'(bus.buffer_write_source), 0);
    rd_base = rd_cycles;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) tick();
    chk("t6_no_receive_done", rd_cycles - rd_base, 0);
    check_drained();
    start_phase(8'hFF);
    all_done();
    wait_done(20);
    check_drained();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
